// File: rtl/audio_pkg.sv
// Shared constants for the codec audio serial paths (DAC transmit and ADC capture).
`timescale 1ns/1ps
package audio_pkg;
  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam logic        LRC_LEFT       = 1'b0;
  localparam int unsigned IDX_W          = 6;
  localparam logic [IDX_W-1:0] IDX_SAT   = 6'd63;
endpackage

// File: rtl/audio_sync.sv
// Synchronizes an asynchronous codec clock into clk and flags its edges.
`timescale 1ns/1ps
module audio_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;
endmodule

// File: rtl/serial_dac.sv
// I2S transmitter: buffers one L/R pair and shifts it MSB-first onto dacdat
// on codec bclk falling edges, with a one-bit delay after each LR transition.
`timescale 1ns/1ps
module serial_dac
  import audio_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bclk,
  input  logic              daclrc,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  output logic              in_ready,
  output logic              dacdat,
  output logic              underrun,
  output logic [7:0]        underrun_cnt
);
  logic bclk_lvl, bclk_fall, bclk_rise_unused;
  logic lrc_lvl, lrc_rise_unused, lrc_fall_unused;
  logic lrc_prev;
  logic pend_full;
  logic [DATA_W-1:0] pend_l, pend_r, shift_l, shift_r;
  logic [DATA_W-1:0] word_sel, word_shifted;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic left_start, right_start, accept, bit_nxt;

  audio_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
    .clk(clk), .reset(reset), .din(bclk),
    .level(bclk_lvl), .rise(bclk_rise_unused), .fall(bclk_fall)
  );

  audio_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lrc_sync (
    .clk(clk), .reset(reset), .din(daclrc),
    .level(lrc_lvl), .rise(lrc_rise_unused), .fall(lrc_fall_unused)
  );

  assign in_ready = ~pend_full;

  // Frame boundaries, bit index and next serial bit for this fall_evt.
  always_comb begin
    left_start  = bclk_fall && (lrc_prev != LRC_LEFT) && (lrc_lvl == LRC_LEFT);
    right_start = bclk_fall && (lrc_prev == LRC_LEFT) && (lrc_lvl != LRC_LEFT);
    accept      = in_valid && !pend_full;
    idx_nxt     = idx;
    if (left_start || right_start) begin
      idx_nxt = '0;
    end else if (idx != IDX_SAT) begin
      idx_nxt = idx + IDX_W'(1);
    end
    word_sel     = (lrc_lvl == LRC_LEFT) ? shift_l : shift_r;
    word_shifted = word_sel << (idx_nxt - IDX_W'(1));
    bit_nxt      = (idx_nxt != '0) && (idx_nxt <= IDX_W'(DATA_W)) &&
                   word_shifted[DATA_W-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_full    <= 1'b0;
      pend_l       <= '0;
      pend_r       <= '0;
      shift_l      <= '0;
      shift_r      <= '0;
      lrc_prev     <= 1'b0;
      idx          <= IDX_SAT;
      dacdat       <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      underrun <= 1'b0;
      if (left_start && pend_full) begin
        pend_full <= 1'b0;
      end else if (accept) begin
        pend_full <= 1'b1;
      end
      if (accept) begin
        pend_l <= in_left;
        pend_r <= in_right;
      end
      // Both words latch together at left start so a pair never splits across frames.
      if (left_start) begin
        shift_l <= pend_full ? pend_l : '0;
        shift_r <= pend_full ? pend_r : '0;
        if (!pend_full) begin
          underrun <= 1'b1;
          if (underrun_cnt != 8'hFF) begin
            underrun_cnt <= underrun_cnt + 8'd1;
          end
        end
      end
      if (bclk_fall) begin
        lrc_prev <= lrc_lvl;
        idx      <= idx_nxt;
        dacdat   <= bit_nxt;
      end
    end
  end
endmodule

// File: tb/tb_serial_dac.sv
// Scoreboard bench for serial_dac: a 32-bit and a 16-bit instance share one codec clock model.
`timescale 1ns/1ps
module tb_serial_dac;
  typedef struct {
    int          frame;
    int          which;
    logic [31:0] l;
    logic [31:0] r;
    int          dw;
    bit          skip_left;
  } exp_t;

  logic clk, reset, bclk, daclrc;
  logic        in_valid32, in_ready32, dacdat32, underrun32;
  logic [31:0] in_left32, in_right32;
  logic [7:0]  underrun_cnt32;
  logic        in_valid16, in_ready16, dacdat16, underrun16;
  logic [15:0] in_left16, in_right16;
  logic [7:0]  underrun_cnt16;

  int n_checks = 0;
  int n_fail   = 0;
  int frame_cnt, gen_chan, gen_pos, gen_len, slot_len, ur_pulses;
  event left_ev;
  exp_t q[$];
  logic [63:0] obs_l32, obs_r32, obs_l16, obs_r16;

  serial_dac #(.DATA_W(32), .SYNC_STAGES(2)) dut32 (
    .clk(clk), .reset(reset), .bclk(bclk), .daclrc(daclrc),
    .in_valid(in_valid32), .in_left(in_left32), .in_right(in_right32),
    .in_ready(in_ready32), .dacdat(dacdat32), .underrun(underrun32),
    .underrun_cnt(underrun_cnt32)
  );

  serial_dac #(.DATA_W(16), .SYNC_STAGES(2)) dut16 (
    .clk(clk), .reset(reset), .bclk(bclk), .daclrc(daclrc),
    .in_valid(in_valid16), .in_left(in_left16), .in_right(in_right16),
    .in_ready(in_ready16), .dacdat(dacdat16), .underrun(underrun16),
    .underrun_cnt(underrun_cnt16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Codec model: bclk period 80 ns (8 clk), edges 3 ns ahead of clk rises.
  initial begin
    bclk = 1'b1; daclrc = 1'b1; frame_cnt = 0; gen_chan = 0; gen_pos = 0;
    slot_len = 40; gen_len = 40;
    #2;
    forever begin
      for (int ch = 0; ch < 2; ch++) begin
        for (int p = 0; p < gen_len; p++) begin
          bclk = 1'b0;
          if (p == 0) begin
            daclrc = (ch == 1);
            if (ch == 0) begin
              gen_len = slot_len;
              frame_cnt++;
              -> left_ev;
            end
          end
          gen_chan = ch;
          gen_pos  = p;
          #40 bclk = 1'b1;
          #40;
        end
      end
    end
  end

  always @(negedge clk) if (underrun32 === 1'b1) ur_pulses++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_slot(input logic [31:0] w, input int dw, input int len);
    logic [63:0] v = '0;
    for (int p = 1; p < len && p <= dw; p++) v[6'(p)] = 1'(w >> (dw - p));
    return v;
  endfunction

  task automatic push(input int frame, input int which, input logic [31:0] l,
                      input logic [31:0] r, input bit skip_left);
    exp_t e;
    e.frame = frame; e.which = which; e.l = l; e.r = r;
    e.dw = (which == 0) ? 32 : 16; e.skip_left = skip_left;
    q.push_back(e);
  endtask

  // Monitor: capture dacdat on codec bclk rises, score whole frames.
  initial begin
    obs_l32 = '0; obs_r32 = '0; obs_l16 = '0; obs_r16 = '0;
    forever begin
      @(posedge bclk);
      if (gen_chan == 0) begin
        if (gen_pos == 0) begin obs_l32 = '0; obs_l16 = '0; end
        obs_l32[6'(gen_pos)] = dacdat32;
        obs_l16[6'(gen_pos)] = dacdat16;
      end else begin
        if (gen_pos == 0) begin obs_r32 = '0; obs_r16 = '0; end
        obs_r32[6'(gen_pos)] = dacdat32;
        obs_r16[6'(gen_pos)] = dacdat16;
      end
      if (gen_chan == 1 && gen_pos == gen_len - 1) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (q[i].frame < frame_cnt) begin
            check($sformatf("frame%0d_dut%0d_missed", q[i].frame, q[i].dw),
                  64'(frame_cnt), 64'(q[i].frame));
            q.delete(i);
          end else if (q[i].frame == frame_cnt) begin
            if (!q[i].skip_left)
              check($sformatf("frame%0d_dut%0d_left", frame_cnt, q[i].dw),
                    (q[i].which == 0) ? obs_l32 : obs_l16,
                    exp_slot(q[i].l, q[i].dw, gen_len));
            check($sformatf("frame%0d_dut%0d_right", frame_cnt, q[i].dw),
                  (q[i].which == 0) ? obs_r32 : obs_r16,
                  exp_slot(q[i].r, q[i].dw, gen_len));
            q.delete(i);
          end
        end
      end
    end
  end

  // Offer a pair and wait (bounded) for it to be taken; optionally keep in_valid up.
  task automatic send(input int which, input logic [31:0] l, input logic [31:0] r, input bit hold);
    bit done = 1'b0;
    @(negedge clk);
    if (which == 0) begin in_valid32 = 1'b1; in_left32 = l; in_right32 = r; end
    else begin in_valid16 = 1'b1; in_left16 = l[15:0]; in_right16 = r[15:0]; end
    for (int i = 0; i < 5000 && !done; i++) begin
      if (((which == 0) ? in_ready32 : in_ready16) === 1'b1) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!hold) begin
      if (which == 0) in_valid32 = 1'b0; else in_valid16 = 1'b0;
    end
    check("accept_wait", 64'(done), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ur_pulses = 0;
    reset = 1'b1;
    in_valid32 = 1'b0; in_left32 = '0; in_right32 = '0;
    in_valid16 = 1'b0; in_left16 = '0; in_right16 = '0;
    #50;
    check("rst_dacdat", 64'(dacdat32), 64'd0);
    check("rst_in_ready", 64'(in_ready32), 64'd1);
    check("rst_underrun", 64'(underrun32), 64'd0);
    check("rst_underrun_cnt", 64'(underrun_cnt32), 64'd0);
    #50 reset = 1'b0;

    // Starvation: frames 2..5 are the first left starts after reset.
    for (int f = 2; f <= 5; f++) push(f, 0, 32'h0, 32'h0, 1'b0);
    wait (frame_cnt == 2);
    check("no_underrun_before_first_left", 64'(ur_pulses), 64'd0);
    wait (frame_cnt == 5);
    check("underrun_pulses_3", 64'(ur_pulses), 64'd3);
    check("underrun_cnt_3", 64'(underrun_cnt32), 64'd3);

    repeat (10) @(posedge clk);
    send(0, 32'h8000_0001, 32'h7FFF_FFFE, 1'b0);
    check("basic_ready_low", 64'(in_ready32), 64'd0);
    push(6, 0, 32'h8000_0001, 32'h7FFF_FFFE, 1'b0);

    wait (frame_cnt == 6);
    repeat (10) @(posedge clk);
    #1 check("ready_after_consume", 64'(in_ready32), 64'd1);
    for (int k = 1; k <= 3; k++) push(6 + k, 0, 32'(k), 32'(k), 1'b0);
    push(10, 0, 32'h0, 32'h0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      send(0, 32'(k), 32'(k), k != 3);
      check($sformatf("bp_pair%0d_ready_low", k), 64'(in_ready32), 64'd0);
      check($sformatf("bp_pair%0d_frame", k), 64'(frame_cnt), 64'(5 + k));
    end

    // Accept while empty in the exact left-start cycle of frame 11.
    wait (frame_cnt == 10);
    @(left_ev);
    @(posedge clk);
    @(posedge clk);
    #1 in_valid32 = 1'b1; in_left32 = 32'h1234_5678; in_right32 = 32'h9ABC_DEF0;
    @(posedge clk);
    #1 in_valid32 = 1'b0;
    check("simul_underrun", 64'(underrun32), 64'd1);
    check("simul_ready_low", 64'(in_ready32), 64'd0);
    check("simul_cnt", 64'(underrun_cnt32), 64'd6);
    @(posedge clk);
    #1 check("simul_underrun_one_cycle", 64'(underrun32), 64'd0);
    push(11, 0, 32'h0, 32'h0, 1'b0);
    push(12, 0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);

    wait (frame_cnt == 12);
    repeat (10) @(posedge clk);
    send(1, 32'h0000_A5A5, 32'h0000_5A5A, 1'b0);
    push(13, 1, 32'h0000_A5A5, 32'h0000_5A5A, 1'b0);

    wait (frame_cnt == 13);
    push(13, 0, 32'h0, 32'h0, 1'b0);
    repeat (10) @(posedge clk);
    send(0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0);
    push(14, 0, 32'h0, 32'h0, 1'b1);

    wait (frame_cnt == 14);
    repeat (10) @(posedge clk);
    send(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("pending_before_reset", 64'(in_ready32), 64'd0);
    push(15, 0, 32'h0, 32'h0, 1'b0);
    push(16, 0, 32'h0, 32'h0, 1'b0);
    wait (frame_cnt == 14 && gen_chan == 0 && gen_pos == 10);
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_dacdat", 64'(dacdat32), 64'd0);
    check("midrst_in_ready", 64'(in_ready32), 64'd1);
    check("midrst_cnt", 64'(underrun_cnt32), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    wait (frame_cnt == 16);
    repeat (10) @(posedge clk);
    #1 check("cnt_after_reset", 64'(underrun_cnt32), 64'd2);
    slot_len = 2;

    wait (frame_cnt == 330);
    repeat (20) @(posedge clk);
    #1 check("cnt_saturated", 64'(underrun_cnt32), 64'd255);
    check("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
